// File: rtl/easyaxi_rd_slv_pkg.sv
// Shared AXI widths/encodings plus the AR request record and beat-address helper
// used by the EASYAXI read slave.
package easyaxi_rd_slv_pkg;

    localparam int unsigned AXI_ID_W    = 4;
    localparam int unsigned AXI_ADDR_W  = 32;
    localparam int unsigned AXI_DATA_W  = 32;
    localparam int unsigned AXI_LEN_W   = 8;
    localparam int unsigned AXI_SIZE_W  = 3;
    localparam int unsigned AXI_BURST_W = 2;
    localparam int unsigned AXI_RESP_W  = 2;

    localparam logic [AXI_BURST_W-1:0] BURST_FIXED = 2'd0;
    localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'd1;
    localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = 2'd2;
    localparam logic [AXI_BURST_W-1:0] BURST_RSVD  = 2'd3;

    localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'd0;
    localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'd2;
    localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'd3;

    typedef struct packed {
        logic [AXI_ID_W-1:0]    id;
        logic [AXI_ADDR_W-1:0]  addr;
        logic [AXI_LEN_W-1:0]   len;
        logic [AXI_SIZE_W-1:0]  size;
        logic [AXI_BURST_W-1:0] burst;
    } ar_req_t;

    function automatic logic [AXI_ADDR_W-1:0] next_addr(
        input logic [AXI_ADDR_W-1:0]  addr,
        input logic [AXI_LEN_W-1:0]   len,
        input logic [AXI_SIZE_W-1:0]  size,
        input logic [AXI_BURST_W-1:0] burst
    );
        logic [AXI_ADDR_W-1:0] inc;
        logic [AXI_ADDR_W-1:0] mask;
        inc  = addr + (AXI_ADDR_W'(1) << size);
        // Wrap window is (len+1)*bytes; legal WRAP lengths keep it a power of two.
        mask = ((AXI_ADDR_W'(len) + AXI_ADDR_W'(1)) << size) - AXI_ADDR_W'(1);
        case (burst)
            BURST_FIXED: return addr;
            BURST_WRAP:  return (addr & ~mask) | (inc & mask);
            default:     return inc;
        endcase
    endfunction

endpackage

// File: rtl/easyaxi_sync_fifo.sv
// Single-clock circular FIFO with a registered full flag, so the upstream ready
// carries no combinational path from the pop side.
module easyaxi_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = full_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // full reads as set during reset so upstream stalls until the cycle after release
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/easyaxi_rd_slv.sv
// AXI read slave: queues AR requests in order and replays each burst on R with
// address-derived data, SLVERR for illegal bursts and DECERR outside MEM_BYTES.
module easyaxi_rd_slv
    import easyaxi_rd_slv_pkg::*;
#(
    parameter int unsigned OST_DEPTH = 8,
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   axi_slv_arvalid,
    output logic                   axi_slv_arready,
    input  logic [AXI_ID_W-1:0]    axi_slv_arid,
    input  logic [AXI_ADDR_W-1:0]  axi_slv_araddr,
    input  logic [AXI_LEN_W-1:0]   axi_slv_arlen,
    input  logic [AXI_SIZE_W-1:0]  axi_slv_arsize,
    input  logic [AXI_BURST_W-1:0] axi_slv_arburst,
    output logic                   axi_slv_rvalid,
    input  logic                   axi_slv_rready,
    output logic [AXI_ID_W-1:0]    axi_slv_rid,
    output logic [AXI_DATA_W-1:0]  axi_slv_rdata,
    output logic [AXI_RESP_W-1:0]  axi_slv_rresp,
    output logic                   axi_slv_rlast
);
    localparam logic [AXI_SIZE_W-1:0] MAX_SIZE = AXI_SIZE_W'($clog2(AXI_DATA_W / 8));

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e                 state_q;
    ar_req_t                ar_req, head;
    logic                   fifo_full, fifo_empty, pop;
    logic                   head_illegal, beat_illegal, illegal_q;
    logic [AXI_ADDR_W-1:0]  addr_nxt, beat_addr, cur_addr_q;
    logic [AXI_LEN_W-1:0]   beat_cnt_q, len_q;
    logic [AXI_SIZE_W-1:0]  size_q;
    logic [AXI_BURST_W-1:0] burst_q;
    logic [AXI_DATA_W-1:0]  beat_data, rdata_q;
    logic [AXI_RESP_W-1:0]  beat_resp, rresp_q;
    logic [AXI_ID_W-1:0]    rid_q;
    logic                   rvalid_q, rlast_q;

    assign ar_req = '{id: axi_slv_arid, addr: axi_slv_araddr, len: axi_slv_arlen,
                      size: axi_slv_arsize, burst: axi_slv_arburst};
    assign axi_slv_arready = ~fifo_full;
    assign pop = (state_q == StIdle) && !fifo_empty;

    easyaxi_sync_fifo #(
        .WIDTH ($bits(ar_req_t)),
        .DEPTH (OST_DEPTH)
    ) u_ar_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (axi_slv_arvalid),
        .din_i   (ar_req),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Response of the beat about to be registered: the head on load, else the next address.
    always_comb begin
        head_illegal = (head.burst == BURST_RSVD) || (head.len > AXI_LEN_W'(7)) ||
                       (head.size > MAX_SIZE) ||
                       ((head.burst == BURST_WRAP) && !((head.len == AXI_LEN_W'(1)) ||
                        (head.len == AXI_LEN_W'(3)) || (head.len == AXI_LEN_W'(7))));
        addr_nxt     = next_addr(cur_addr_q, len_q, size_q, burst_q);
        beat_addr    = (state_q == StIdle) ? head.addr : addr_nxt;
        beat_illegal = (state_q == StIdle) ? head_illegal : illegal_q;
        beat_data    = '0;
        beat_resp    = RESP_OKAY;
        if (beat_illegal) begin
            beat_resp = RESP_SLVERR;
        end else if (beat_addr >= AXI_ADDR_W'(MEM_BYTES)) begin
            beat_resp = RESP_DECERR;
        end else begin
            beat_data = AXI_DATA_W'(beat_addr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cur_addr_q <= '0;
            beat_cnt_q <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            illegal_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rid_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            rlast_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        state_q    <= StBurst;
                        cur_addr_q <= head.addr;
                        beat_cnt_q <= '0;
                        len_q      <= head.len;
                        size_q     <= head.size;
                        burst_q    <= head.burst;
                        illegal_q  <= head_illegal;
                        rvalid_q   <= 1'b1;
                        rid_q      <= head.id;
                        rdata_q    <= beat_data;
                        rresp_q    <= beat_resp;
                        rlast_q    <= (head.len == '0);
                    end
                end
                StBurst: begin
                    if (axi_slv_rready) begin
                        if (rlast_q) begin
                            state_q  <= StIdle;
                            rvalid_q <= 1'b0;
                            rid_q    <= '0;
                            rdata_q  <= '0;
                            rresp_q  <= '0;
                            rlast_q  <= 1'b0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + AXI_LEN_W'(1);
                            cur_addr_q <= addr_nxt;
                            rdata_q    <= beat_data;
                            rresp_q    <= beat_resp;
                            rlast_q    <= (beat_cnt_q + AXI_LEN_W'(1) == len_q);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign axi_slv_rvalid = rvalid_q;
    assign axi_slv_rid    = rid_q;
    assign axi_slv_rdata  = rdata_q;
    assign axi_slv_rresp  = rresp_q;
    assign axi_slv_rlast  = rlast_q;

endmodule

// File: tb/tb_easyaxi_rd_slv.sv
// Directed bench for easyaxi_rd_slv: reset, latency, burst types, queue full,
// backpressure stability, error responses and mid-burst reset.
module tb_easyaxi_rd_slv;
    import easyaxi_rd_slv_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   axi_slv_arvalid = 1'b0;
    logic                   axi_slv_arready;
    logic [AXI_ID_W-1:0]    axi_slv_arid = '0;
    logic [AXI_ADDR_W-1:0]  axi_slv_araddr = '0;
    logic [AXI_LEN_W-1:0]   axi_slv_arlen = '0;
    logic [AXI_SIZE_W-1:0]  axi_slv_arsize = '0;
    logic [AXI_BURST_W-1:0] axi_slv_arburst = '0;
    logic                   axi_slv_rvalid;
    logic                   axi_slv_rready = 1'b0;
    logic [AXI_ID_W-1:0]    axi_slv_rid;
    logic [AXI_DATA_W-1:0]  axi_slv_rdata;
    logic [AXI_RESP_W-1:0]  axi_slv_rresp;
    logic                   axi_slv_rlast;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic rand_rdy = 1'b0;
    logic [31:0] exp_data[$];
    logic [1:0]  exp_resp[$];
    logic [38:0] r_bus;

    assign r_bus = {axi_slv_rid, axi_slv_rdata, axi_slv_rresp, axi_slv_rlast};

    easyaxi_rd_slv #(
        .OST_DEPTH (8),
        .MEM_BYTES (256)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .axi_slv_arvalid (axi_slv_arvalid),
        .axi_slv_arready (axi_slv_arready),
        .axi_slv_arid    (axi_slv_arid),
        .axi_slv_araddr  (axi_slv_araddr),
        .axi_slv_arlen   (axi_slv_arlen),
        .axi_slv_arsize  (axi_slv_arsize),
        .axi_slv_arburst (axi_slv_arburst),
        .axi_slv_rvalid  (axi_slv_rvalid),
        .axi_slv_rready  (axi_slv_rready),
        .axi_slv_rid     (axi_slv_rid),
        .axi_slv_rdata   (axi_slv_rdata),
        .axi_slv_rresp   (axi_slv_rresp),
        .axi_slv_rlast   (axi_slv_rlast)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that takes the AR.
    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int w = 0;
        axi_slv_arvalid = 1'b1;
        axi_slv_arid = id;
        axi_slv_araddr = addr;
        axi_slv_arlen = len;
        axi_slv_arsize = size;
        axi_slv_arburst = burst;
        @(negedge clk);
        while (!axi_slv_arready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) check_eq("ar_timeout", 64'(axi_slv_arready), 64'd1);
        @(posedge clk);
        #1;
        axi_slv_arvalid = 1'b0;
    endtask

    task automatic okay_resp();
        exp_resp.delete();
        for (int i = 0; i < exp_data.size(); i++) exp_resp.push_back(RESP_OKAY);
    endtask

    // Receives one burst against exp_data/exp_resp; gap = stalled cycles before beat 0.
    task automatic recv_burst(input string tag, input logic [3:0] id, output int gap);
        logic [38:0] hold;
        logic        stalled;
        int          n;
        n = exp_data.size();
        gap = 0;
        for (int i = 0; i < n; i++) begin
            int w = 0;
            @(negedge clk);
            while (!(axi_slv_rvalid && axi_slv_rready) && w < 200) begin
                stalled = axi_slv_rvalid;
                hold = r_bus;
                @(posedge clk);
                #1;
                if (rand_rdy) axi_slv_rready = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (stalled) check_eq({tag, "_hold"}, {axi_slv_rvalid, r_bus}, {1'b1, hold});
                w++;
            end
            if (w >= 200) begin
                check_eq({tag, "_timeout"}, 64'(axi_slv_rvalid & axi_slv_rready), 64'd1);
                return;
            end
            if (i == 0) gap = w;
            check_eq({tag, "_rid"}, 64'(axi_slv_rid), 64'(id));
            check_eq({tag, "_rdata"}, 64'(axi_slv_rdata), 64'(exp_data[i]));
            check_eq({tag, "_rresp"}, 64'(axi_slv_rresp), 64'(exp_resp[i]));
            check_eq({tag, "_rlast"}, 64'(axi_slv_rlast), 64'(i == n - 1));
            @(posedge clk);
            #1;
            if (rand_rdy) axi_slv_rready = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        int gap;
        int raise_cyc;
        int acc_cyc;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_arready", 64'(axi_slv_arready), 64'd0);
        check_eq("rst_r", {axi_slv_rvalid, r_bus}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rel_arready", 64'(axi_slv_arready), 64'd0);
        check_eq("rel_rvalid", 64'(axi_slv_rvalid), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rel_arready_up", 64'(axi_slv_arready), 64'd1);
        @(posedge clk);
        #1;

        // Single INCR beat, first rvalid two cycles after the handshake
        axi_slv_rready = 1'b1;
        send_ar(4'd0, 32'h00, 8'd0, 3'd2, BURST_INCR);
        @(negedge clk);
        check_eq("lat_t1_rvalid", 64'(axi_slv_rvalid), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("lat_t2_beat", {axi_slv_rvalid, r_bus}, {1'b1, 4'd0, 32'h0, 2'd0, 1'b1});
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("lat_t3_rvalid", 64'(axi_slv_rvalid), 64'd0);
        @(posedge clk);
        #1;

        // WRAP and FIXED bursts with random rready
        axi_slv_rready = 1'b0;
        send_ar(4'd4, 32'h34, 8'd3, 3'd2, BURST_WRAP);
        send_ar(4'd5, 32'h38, 8'd7, 3'd2, BURST_WRAP);
        send_ar(4'd6, 32'h40, 8'd7, 3'd2, BURST_FIXED);
        rand_rdy = 1'b1;
        exp_data = '{32'h34, 32'h38, 32'h3C, 32'h30};
        okay_resp();
        recv_burst("wrap4", 4'd4, gap);
        exp_data = '{32'h38, 32'h3C, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h34};
        okay_resp();
        recv_burst("wrap8", 4'd5, gap);
        exp_data = '{32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40};
        okay_resp();
        recv_burst("fixed8", 4'd6, gap);
        rand_rdy = 1'b0;

        // Error responses
        axi_slv_rready = 1'b1;
        send_ar(4'd7, 32'h10, 8'd1, 3'd2, BURST_RSVD);
        exp_data = '{32'h0, 32'h0};
        exp_resp = '{RESP_SLVERR, RESP_SLVERR};
        recv_burst("rsvd", 4'd7, gap);
        send_ar(4'd8, 32'hFC, 8'd1, 3'd2, BURST_INCR);
        exp_data = '{32'hFC, 32'h0};
        exp_resp = '{RESP_OKAY, RESP_DECERR};
        recv_burst("decerr", 4'd8, gap);
        send_ar(4'd9, 32'h20, 8'd2, 3'd2, BURST_WRAP);
        exp_data = '{32'h0, 32'h0, 32'h0};
        exp_resp = '{RESP_SLVERR, RESP_SLVERR, RESP_SLVERR};
        recv_burst("wrap_len2", 4'd9, gap);
        send_ar(4'd10, 32'h20, 8'd0, 3'd3, BURST_INCR);
        exp_data = '{32'h0};
        exp_resp = '{RESP_SLVERR};
        recv_burst("size8", 4'd10, gap);

        // Fill the queue behind a stalled burst, then drain in order
        axi_slv_rready = 1'b0;
        send_ar(4'd0, 32'h00, 8'd1, 3'd2, BURST_INCR);
        for (int k = 1; k <= 8; k++) begin
            axi_slv_arvalid = 1'b1;
            axi_slv_arid = 4'(k);
            axi_slv_araddr = 32'(k * 16);
            axi_slv_arlen = 8'd1;
            axi_slv_arsize = 3'd2;
            axi_slv_arburst = BURST_INCR;
            @(negedge clk);
            check_eq("fill_arready", 64'(axi_slv_arready), 64'd1);
            @(posedge clk);
            #1;
        end
        axi_slv_arid = 4'd9;
        axi_slv_araddr = 32'h90;
        @(negedge clk);
        check_eq("full_arready", 64'(axi_slv_arready), 64'd0);
        check_eq("stall_beat", {axi_slv_rvalid, r_bus}, {1'b1, 4'd0, 32'h0, 2'd0, 1'b0});
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("full_arready2", 64'(axi_slv_arready), 64'd0);
        check_eq("stall_beat2", {axi_slv_rvalid, r_bus}, {1'b1, 4'd0, 32'h0, 2'd0, 1'b0});
        @(posedge clk);
        #1;
        axi_slv_rready = 1'b1;
        raise_cyc = cyc;
        acc_cyc = 0;
        fork
            begin
                int w = 0;
                @(negedge clk);
                while (!axi_slv_arready && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                acc_cyc = cyc;
                @(posedge clk);
                #1;
                axi_slv_arvalid = 1'b0;
            end
            begin
                for (int b = 0; b <= 9; b++) begin
                    exp_data = '{32'(b * 16), 32'(b * 16 + 4)};
                    okay_resp();
                    recv_burst("drain", 4'(b), gap);
                    if (b > 0) check_eq("drain_gap", 64'(gap), 64'd1);
                end
            end
        join
        check_eq("ar9_accept_cycle", 64'(acc_cyc - raise_cyc), 64'd3);

        // Reset mid-burst with a queued request behind it
        axi_slv_rready = 1'b0;
        send_ar(4'd3, 32'h40, 8'd7, 3'd2, BURST_FIXED);
        send_ar(4'd2, 32'h44, 8'd0, 3'd2, BURST_INCR);
        @(negedge clk);
        check_eq("pre_rst_rvalid", 64'(axi_slv_rvalid), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        axi_slv_rready = 1'b1;
        @(negedge clk);
        check_eq("post_rst_rvalid", 64'(axi_slv_rvalid), 64'd0);
        check_eq("post_rst_arready", 64'(axi_slv_arready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_eq("post_rst_empty", 64'(axi_slv_rvalid), 64'd0);
        end
        check_eq("post_rst_arready_up", 64'(axi_slv_arready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
